// File: rtl/ifetch_seq.sv
// ifetch_seq: instruction-fetch sequencer; owns the PC, fetches over a
// req/ack memory handshake and hands one instruction at a time to decode.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   imem_req/addr/ack/data   instruction memory, single outstanding request
//   inst/inst_pc/inst_valid  registered instruction to decode
//   inst_ready               consumer retires inst
//   takeBr/brTarget          branch redirect, sampled on retire only
//   jump/jumpTarget          jump redirect (wins over branch), retire only
//   misalign                 sticky: a redirect target had addr[1:0]!=0
// Config: DELAY_SLOT_EN adds one architectural branch delay slot.
module ifetch_seq #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_data,
  output logic [WIDTH-1:0] inst,
  output logic [WIDTH-1:0] inst_pc,
  output logic             inst_valid,
  input  logic             inst_ready,
  input  logic             takeBr,
  input  logic [WIDTH-1:0] brTarget,
  input  logic             jump,
  input  logic [WIDTH-1:0] jumpTarget,
  output logic             misalign
);

  localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD
  } state_t;

  state_t           state;
  state_t           stateNext;
  logic [WIDTH-1:0] addrQ;
  logic [WIDTH-1:0] addrNext;
  logic [WIDTH-1:0] instQ;
  logic [WIDTH-1:0] instNext;
  logic [WIDTH-1:0] pcQ;
  logic [WIDTH-1:0] pcNext;
  logic             misQ;
  logic             misNext;

  logic [WIDTH-1:0] seqPc;
  logic [WIDTH-1:0] tgtRaw;
  logic [WIDTH-1:0] tgtAlign;
  logic             tgtMis;
  logic             redirect;

`ifdef DELAY_SLOT_EN
  logic             pendQ;
  logic             pendNext;
  logic [WIDTH-1:0] pendAddrQ;
  logic [WIDTH-1:0] pendAddrNext;
`endif

  // Wraps naturally modulo 2^WIDTH.
  assign seqPc    = pcQ + PC_STEP;
  assign redirect = jump | takeBr;
  // Jump has priority over a taken branch.
  assign tgtRaw   = jump ? jumpTarget : brTarget;
  assign tgtAlign = {tgtRaw[WIDTH-1:2], 2'b00};
  assign tgtMis   = |tgtRaw[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      addrQ <= RESET_PC;
      instQ <= '0;
      pcQ   <= RESET_PC;
      misQ  <= 1'b0;
`ifdef DELAY_SLOT_EN
      pendQ     <= 1'b0;
      pendAddrQ <= RESET_PC;
`endif
    end else begin
      state <= stateNext;
      addrQ <= addrNext;
      instQ <= instNext;
      pcQ   <= pcNext;
      misQ  <= misNext;
`ifdef DELAY_SLOT_EN
      pendQ     <= pendNext;
      pendAddrQ <= pendAddrNext;
`endif
    end
  end

  always_comb begin
    stateNext = state;
    addrNext  = addrQ;
    instNext  = instQ;
    pcNext    = pcQ;
    misNext   = misQ;
`ifdef DELAY_SLOT_EN
    pendNext     = pendQ;
    pendAddrNext = pendAddrQ;
`endif
    unique case (state)
      IDLE: stateNext = FETCH;
      FETCH: begin
        if (imem_ack) begin
          instNext  = imem_data;
          pcNext    = addrQ;
          stateNext = HOLD;
        end
      end
      HOLD: begin
        if (inst_ready) begin
          stateNext = FETCH;
`ifdef DELAY_SLOT_EN
          // The slot instruction retiring releases
          // the held target; its own redirect is
          // dropped.
          unique case (1'b1)
            pendQ: begin
              addrNext = pendAddrQ;
              pendNext = 1'b0;
            end
            (!pendQ && redirect): begin
              addrNext     = seqPc;
              pendNext     = 1'b1;
              pendAddrNext = tgtAlign;
              misNext      = misQ | tgtMis;
            end
            default: addrNext = seqPc;
          endcase
`else
          unique case (1'b1)
            redirect: begin
              addrNext = tgtAlign;
              misNext  = misQ | tgtMis;
            end
            default: addrNext = seqPc;
          endcase
`endif
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign imem_req   = (state == FETCH);
  assign imem_addr  = addrQ;
  assign inst       = instQ;
  assign inst_pc    = pcQ;
  assign inst_valid = (state == HOLD);
  assign misalign   = misQ;

endmodule

// File: tb/tb_ifetch_seq.sv
// tb_ifetch_seq: vector table, directed corner sequences and
// randomized traffic against a sequence-level PC model.
module tb_ifetch_seq;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        takeBr;
  logic [31:0] brTarget;
  logic        jump;
  logic [31:0] jumpTarget;
  logic        misalign;

  int nCmp = 0;
  int nBad = 0;

  ifetch_seq #(
    .WIDTH(32),
    .RESET_PC(32'h0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_data(imem_data),
    .inst(inst),
    .inst_pc(inst_pc),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .takeBr(takeBr),
    .brTarget(brTarget),
    .jump(jump),
    .jumpTarget(jumpTarget),
    .misalign(misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic        takeB;
    logic [31:0] bT;
    logic        jmp;
    logic [31:0] jT;
    logic [31:0] expAddr;
    logic        expMis;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic tb, input logic [31:0] bt,
    input logic jm, input logic [31:0] jt,
    input logic [31:0] ea, input logic em);
    vec_t v;
    v.takeB = tb; v.bT = bt; v.jmp = jm;
    v.jT = jt; v.expAddr = ea; v.expMis = em;
    return v;
  endfunction

  function automatic logic [31:0] memData(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5679;
  endfunction

  function automatic logic [31:0] rndTgt();
    logic [31:0] t;
    t = $urandom;
    if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
    return t;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic waitReq(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) begin
      nCmp++;
      nBad++;
      $display("FAIL req_timeout: got no imem_req, expected one");
    end
  endtask

  // One instruction: fetch at expAddr, hold with stalls, retire with
  // the given redirect, then check sticky misalign.
  task automatic doInst(input logic takeB, input logic [31:0] bT,
                        input logic jmp, input logic [31:0] jT,
                        input logic [31:0] expAddr, input logic expMis,
                        input int ackDly, input int stall);
    bit ok;
    logic [31:0] d;
    waitReq(ok);
    if (!ok) return;
    chk("fetch_addr", imem_addr, expAddr);
    for (int i = 0; i < ackDly; i++) begin
      imem_ack = 1'b0;
      step();
      chk("req_held", {31'b0, imem_req}, 32'd1);
      chk("addr_stable", imem_addr, expAddr);
    end
    d = memData(expAddr);
    imem_ack = 1'b1;
    imem_data = d;
    step();
    imem_ack = 1'b0;
    imem_data = $urandom;
    chk("valid_set", {31'b0, inst_valid}, 32'd1);
    chk("inst", inst, d);
    chk("inst_pc", inst_pc, expAddr);
    chk("req_off", {31'b0, imem_req}, 32'd0);
    for (int i = 0; i < stall; i++) begin
      inst_ready = 1'b0;
      takeBr = 1'($urandom);
      jump = 1'($urandom);
      brTarget = $urandom;
      jumpTarget = $urandom;
      step();
      chk("stall_valid", {31'b0, inst_valid}, 32'd1);
      chk("stall_inst", inst, d);
      chk("stall_req", {31'b0, imem_req}, 32'd0);
    end
    inst_ready = 1'b1;
    takeBr = takeB;
    brTarget = bT;
    jump = jmp;
    jumpTarget = jT;
    step();
    inst_ready = 1'b0;
    takeBr = 1'b0;
    jump = 1'b0;
    chk("misalign", {31'b0, misalign}, {31'b0, expMis});
    chk("valid_drop", {31'b0, inst_valid}, 32'd0);
  endtask

  initial begin
    bit ok;
    logic [31:0] d;
    logic [31:0] mPc;
    logic [31:0] nxt;
    logic [31:0] t;
    logic [31:0] bT;
    logic [31:0] jT;
    logic        mMis;
    logic        mPendV;
    logic [31:0] mPendA;
    logic        tb;
    logic        jm;
    int          r;

`ifdef DELAY_SLOT_EN
    tbl.push_back(mk(0, 0, 0, 0, 32'h0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 32'h4, 0));
    tbl.push_back(mk(1, 32'h100, 0, 0, 32'h8, 0));
    tbl.push_back(mk(1, 32'h301, 0, 0, 32'hC, 0));
    tbl.push_back(mk(1, 32'h100, 1, 32'h202, 32'h100, 1));
    tbl.push_back(mk(0, 0, 0, 0, 32'h104, 1));
    tbl.push_back(mk(1, 32'hFFFF_FFFC, 0, 0, 32'h200, 1));
    tbl.push_back(mk(0, 0, 0, 0, 32'h204, 1));
    tbl.push_back(mk(0, 0, 0, 0, 32'hFFFF_FFFC, 1));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0, 1));
`else
    tbl.push_back(mk(0, 0, 0, 0, 32'h0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 32'h4, 0));
    tbl.push_back(mk(1, 32'h100, 0, 0, 32'h8, 0));
    tbl.push_back(mk(1, 32'h100, 1, 32'h200, 32'h100, 0));
    tbl.push_back(mk(0, 0, 0, 0, 32'h200, 0));
    tbl.push_back(mk(0, 0, 1, 32'h202, 32'h204, 1));
    tbl.push_back(mk(1, 32'hFFFF_FFFC, 0, 0, 32'h200, 1));
    tbl.push_back(mk(0, 0, 0, 0, 32'hFFFF_FFFC, 1));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0, 1));
`endif

    rst = 1'b1;
    imem_ack = 1'b0;
    imem_data = '0;
    inst_ready = 1'b0;
    takeBr = 1'b0;
    brTarget = '0;
    jump = 1'b0;
    jumpTarget = '0;

    step();
    step();
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_pc", inst_pc, 32'h0);
    chk("rst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_mis", {31'b0, misalign}, 32'd0);
    rst = 1'b0;
    step();
    chk("first_req", {31'b0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0);

    foreach (tbl[i])
      doInst(tbl[i].takeB, tbl[i].bT, tbl[i].jmp, tbl[i].jT,
             tbl[i].expAddr, tbl[i].expMis,
             $urandom_range(0, 2), $urandom_range(0, 2));

    // Long stall with branch pulses that must be ignored.
    waitReq(ok);
    chk("stall_addr", imem_addr, 32'h4);
    d = memData(32'h4);
    imem_ack = 1'b1;
    imem_data = d;
    step();
    imem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      takeBr = i[0];
      brTarget = 32'h40;
      step();
      chk("hold_valid", {31'b0, inst_valid}, 32'd1);
      chk("hold_inst", inst, d);
      chk("hold_pc", inst_pc, 32'h4);
      chk("hold_req", {31'b0, imem_req}, 32'd0);
    end
    takeBr = 1'b0;
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;

    // Reset arriving together with an ack.
    waitReq(ok);
    chk("pre_rst_addr", imem_addr, 32'h8);
    imem_ack = 1'b1;
    imem_data = 32'hCAFE_F00D;
    rst = 1'b1;
    step();
    imem_ack = 1'b0;
    chk("rst2_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst2_req", {31'b0, imem_req}, 32'd0);
    chk("rst2_addr", imem_addr, 32'h0);
    chk("rst2_inst", inst, 32'h0);
    chk("rst2_mis", {31'b0, misalign}, 32'd0);
    rst = 1'b0;

    // Randomized traffic against the sequence-level model.
    mPc = 32'h0;
    mMis = 1'b0;
    mPendV = 1'b0;
    mPendA = 32'h0;
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 9);
      tb = (r < 3) || (r == 4);
      jm = (r == 3) || (r == 4);
      bT = rndTgt();
      jT = rndTgt();
      t = jm ? jT : bT;
`ifdef DELAY_SLOT_EN
      if (mPendV) begin
        nxt = mPendA;
        mPendV = 1'b0;
      end else if (tb || jm) begin
        if (t[1:0] != 2'b00) mMis = 1'b1;
        mPendA = t & 32'hFFFF_FFFC;
        mPendV = 1'b1;
        nxt = mPc + 32'd4;
      end else begin
        nxt = mPc + 32'd4;
      end
`else
      if (tb || jm) begin
        if (t[1:0] != 2'b00) mMis = 1'b1;
        nxt = t & 32'hFFFF_FFFC;
      end else begin
        nxt = mPc + 32'd4;
      end
`endif
      doInst(tb, bT, jm, jT, mPc, mMis,
             $urandom_range(0, 3), $urandom_range(0, 3));
      mPc = nxt;
    end
    waitReq(ok);
    chk("final_addr", imem_addr, mPc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nCmp, nBad);
    $finish;
  end

endmodule
